// File: rtl/rf_debug_access_pkg.sv
// Shared types and default widths for the debug register-file access block.
package rf_debug_access_pkg;

    localparam int DEF_ADDR_WIDTH     = 5;
    localparam int DEF_DATA_WIDTH     = 32;
    localparam int DEF_TIMEOUT_CYCLES = 255;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HALT,
        ST_ACCESS,
        ST_RESP
    } state_e;

    // Response latch at the default data width; the top re-declares it at its own DATA_WIDTH.
    typedef struct packed {
        logic                      err;
        logic [DEF_DATA_WIDTH-1:0] rdata;
    } rsp_latch_t;

endpackage

// File: rtl/rf_debug_timer.sv
// Saturating halt-wait counter; expired_o rises during the LIMIT-th enabled cycle after a clear.
module rf_debug_timer #(
    parameter int LIMIT = 255
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;

    logic [CW-1:0] count_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            count_q <= '0;
        end else if (en_i && !expired_o) begin
            count_q <= count_q + CW'(1);
        end
    end

    // count_q holds the number of completed waiting cycles, so LIMIT-1 marks the last one.
    assign expired_o = (count_q >= CW'(LIMIT - 1));

endmodule

// File: rtl/rf_debug_access.sv
// Debug-side register-file initiator: halt the core, do one read or write, return a response.
// Optional halt-acknowledge timeout is compiled in with RF_DEBUG_TIMEOUT_EN.
module rf_debug_access
    import rf_debug_access_pkg::*;
#(
    parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic                  cmd_write_i,
    input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
    input  logic [DATA_WIDTH-1:0] cmd_wdata_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [DATA_WIDTH-1:0] rsp_rdata_o,
    output logic                  rsp_err_o,
    output logic                  halt_req_o,
    input  logic                  halt_ack_i,
    output logic                  rf_we_o,
    output logic [ADDR_WIDTH-1:0] rf_rw_o,
    output logic [DATA_WIDTH-1:0] rf_wdata_o,
    output logic [ADDR_WIDTH-1:0] rf_ra_o,
    input  logic [DATA_WIDTH-1:0] rf_rdata_i
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // the offering side holds its payload stable until then.

    typedef struct packed {
        logic                  err;
        logic [DATA_WIDTH-1:0] rdata;
    } rsp_data_t;

    state_e                state_q, state_d;
    logic                  write_q, write_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    rsp_data_t             rsp_q, rsp_d;
    logic                  timeout_hit;
    logic                  addr_is_x0;

    assign addr_is_x0 = (addr_q == '0);

`ifdef RF_DEBUG_TIMEOUT_EN
    logic timer_clear;
    logic timer_en;

    // Held clear outside HALT so every HALT visit starts counting from zero.
    assign timer_clear = (state_q != ST_HALT);
    assign timer_en    = (state_q == ST_HALT);

    rf_debug_timer #(
        .LIMIT(TIMEOUT_CYCLES)
    ) u_timer (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clear_i  (timer_clear),
        .en_i     (timer_en),
        .expired_o(timeout_hit)
    );
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign timeout_hit        = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rsp_q   <= '0;
        end else begin
            state_q <= state_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rsp_q   <= rsp_d;
        end
    end

    always_comb begin
        state_d = state_q;
        write_d = write_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rsp_d   = rsp_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid_i && cmd_ready_o) begin
                    write_d = cmd_write_i;
                    addr_d  = cmd_addr_i;
                    wdata_d = cmd_wdata_i;
                    state_d = ST_HALT;
                end
            end
            ST_HALT: begin
                // An acknowledge arriving in the final waiting cycle still wins over the timeout.
                if (halt_ack_i) begin
                    state_d = ST_ACCESS;
                end else if (timeout_hit) begin
                    rsp_d.err   = 1'b1;
                    rsp_d.rdata = '0;
                    state_d     = ST_RESP;
                end
            end
            ST_ACCESS: begin
                rsp_d.err   = write_q && addr_is_x0;
                rsp_d.rdata = (write_q || addr_is_x0) ? '0 : rf_rdata_i;
                state_d     = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready_i) begin
                    rsp_d   = '0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Every output is decoded from registered state; rst_i only masks the accept.
    assign cmd_ready_o = (state_q == ST_IDLE) && !rst_i;
    assign halt_req_o  = (state_q == ST_HALT) || (state_q == ST_ACCESS);
    assign rf_we_o     = (state_q == ST_ACCESS) && write_q && !addr_is_x0;
    assign rf_rw_o     = rf_we_o ? addr_q : '0;
    assign rf_wdata_o  = rf_we_o ? wdata_q : '0;
    assign rf_ra_o     = ((state_q == ST_ACCESS) && !write_q) ? addr_q : '0;
    assign rsp_valid_o = (state_q == ST_RESP);
    assign rsp_err_o   = (state_q == ST_RESP) && rsp_q.err;
    assign rsp_rdata_o = (state_q == ST_RESP) ? rsp_q.rdata : '0;

endmodule

// File: doc/rf_debug_access.md
# rf_debug_access

Debug-side initiator for the integer register file: accepts single-register read/write commands from the debug module, halts the core, drives the register file's write port and a dedicated read address, then returns a response. It sits between the debug transport and the regfile's `we/rw/wdata` and read ports, which it owns only while the core acknowledges halt.

## Interface
- `ADDR_WIDTH`, default 5: register index width (2**ADDR_WIDTH registers, x0 hard-wired zero).
- `DATA_WIDTH`, default 32: register data width.
- `TIMEOUT_CYCLES`, default 255: halt-acknowledge wait limit (used only with timeout compiled in).
- `clk_i` in 1: single clock, all logic rising-edge.
- `rst_i` in 1: reset, synchronous and active-high.
- `cmd_valid_i` in 1: command offered.
- `cmd_ready_o` out 1: block can accept a command.
- `cmd_write_i` in 1: 1 = write, 0 = read.
- `cmd_addr_i` in ADDR_WIDTH: target register index.
- `cmd_wdata_i` in DATA_WIDTH: write data.
- `rsp_valid_o` out 1: response available.
- `rsp_ready_i` in 1: response consumed.
- `rsp_rdata_o` out DATA_WIDTH: read data (0 for writes and errors).
- `rsp_err_o` out 1: command failed.
- `halt_req_o` out 1: request core halt.
- `halt_ack_i` in 1: core halted, regfile ports free.
- `rf_we_o` out 1: regfile write enable.
- `rf_rw_o` out ADDR_WIDTH: regfile write index.
- `rf_wdata_o` out DATA_WIDTH: regfile write data.
- `rf_ra_o` out ADDR_WIDTH: regfile read index.
- `rf_rdata_i` in DATA_WIDTH: regfile read data, combinational from `rf_ra_o`.

## Operation
- States: IDLE, HALT, ACCESS, RESP.
- IDLE: `cmd_ready_o`=1. On `cmd_valid_i && cmd_ready_o` latch write/addr/wdata, go HALT.
- HALT: `halt_req_o`=1; when `halt_ack_i`=1 go ACCESS.
- ACCESS (exactly one cycle): `halt_req_o`=1. Write to nonzero index: `rf_we_o`=1, `rf_rw_o`/`rf_wdata_o` = latched values. Write to x0: `rf_we_o` stays 0, error flagged. Read: `rf_ra_o` = latched addr, `rf_rdata_i` registered into response data. Go RESP.
- RESP: `rsp_valid_o`=1, `halt_req_o`=0; response fields stable until `rsp_valid_o && rsp_ready_i`, then IDLE.
- `rf_we_o` never asserted outside ACCESS; `rf_rw_o`, `rf_wdata_o`, `rf_ra_o` are 0 outside ACCESS.
- Read of x0 is legal: returns 0, `rsp_err_o`=0.
- `halt_ack_i` sampled only in HALT; deassertion elsewhere ignored.

## Timing
- Reset: state IDLE; `cmd_ready_o`=0 during reset cycle, 1 the cycle after; all other outputs 0.
- Reset mid-command from any state: returns to IDLE next edge, pending command and response discarded, `halt_req_o` and `rf_we_o` drop immediately at that edge.
- Minimum latency, `halt_ack_i` already high: accept at edge 0, HALT cycle 1, ACCESS cycle 2 (regfile written at end of cycle 2), `rsp_valid_o` cycle 3.
- One command in flight; `cmd_ready_o`=0 in HALT, ACCESS, RESP. Next command accepted earliest the cycle after response handshake.
- All outputs registered or decoded from state register only; no combinational path from `cmd_*` or `rsp_ready_i` to outputs.

## Configuration
- `RF_DEBUG_TIMEOUT_EN` defined: counter runs in HALT; after `TIMEOUT_CYCLES` cycles without `halt_ack_i`, skip ACCESS, go RESP with `rsp_err_o`=1, `rsp_rdata_o`=0, no regfile access. Counter clears on entering HALT.
- Not defined: HALT waits indefinitely; no counter logic present; `TIMEOUT_CYCLES` unused.

## Structure
- Shared package: state enum (IDLE/HALT/ACCESS/RESP), response-latch struct (err, rdata), default width constants.
- One sub-module natural: `rf_debug_timer`, saturating halt-wait counter with clear/enable/expired, instantiated only under `RF_DEBUG_TIMEOUT_EN`.

## Test plan
- Write x5=0xDEADBEEF, halt_ack held high -> `rf_we_o` one cycle at cycle 2, `rf_rw_o`=5; `rsp_valid_o` cycle 3, err 0; subsequent read x5 returns 0xDEADBEEF.
- Write x0=0x1234 -> `rf_we_o` never asserted, `rsp_err_o`=1; read x0 returns 0, err 0.
- halt_ack delayed 10 cycles -> `halt_req_o` high throughout, no regfile activity before ack, response 2 cycles after ack.
- `rsp_ready_i` low 5 cycles -> `rsp_valid_o` and data stable, `cmd_ready_o`=0; new command accepted cycle after handshake.
- `rst_i` pulsed during HALT and during RESP -> next cycle all outputs 0, state IDLE, no write to regfile.
- With `RF_DEBUG_TIMEOUT_EN`, `TIMEOUT_CYCLES`=8, halt_ack never asserted -> error response after 8 HALT cycles, `rf_we_o` never high.
